// File: rtl/serial_frame_checker.sv
// serial_frame_checker: frames a 1-bit stream into FRAME_LEN words on SYNC,
// reports word/popcount/match, tracks pattern lock and a saturating error count.
module serial_frame_checker #(
    parameter int                   FRAME_LEN = 10,
    parameter logic [FRAME_LEN-1:0] EXPECT    = 10'h03F,
    parameter int                   LOCK_N    = 3,
    parameter int                   CW        = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 SIN,
    input  logic                 SYNC,
    output logic [FRAME_LEN-1:0] FRAME,
    output logic                 FRAME_VALID,
    output logic [CW-1:0]        ONES,
    output logic                 MATCH,
    output logic                 LOCKED,
    output logic [7:0]           ERR_CNT
);

    localparam int GW = $clog2(LOCK_N + 1);
    localparam logic [CW-1:0] LAST     = CW'(FRAME_LEN - 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_N);
    localparam logic [GW-1:0] GOOD_PRE = GW'(LOCK_N - 1);

    typedef enum logic {
        HUNT,
        CAPTURE
    } state_t;

    state_t               state;
    logic [FRAME_LEN-1:0] shreg;
    logic [FRAME_LEN-1:0] word;
    logic [CW-1:0]        slot;
    logic [CW-1:0]        ones_nx;
    logic [GW-1:0]        good;
    logic [7:0]           err_nx;
    logic                 word_ok;

    // Completed word: captured slots plus the bit on the wire right now.
    always_comb begin
        word = shreg;
        word[FRAME_LEN-1] = SIN;
        word_ok = (word == EXPECT);
    end

    // Popcount of the completed word, zero-extended into CW bits.
    always_comb begin
        ones_nx = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            ones_nx = ones_nx + CW'(word[i]);
        end
    end

    // Saturating increment of the error counter.
    always_comb begin
        err_nx = (ERR_CNT == 8'hFF) ? ERR_CNT : ERR_CNT + 8'd1;
    end

    // Framing FSM with registered outputs, lock and error tracking.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= HUNT;
            shreg       <= '0;
            slot        <= '0;
            good        <= '0;
            FRAME       <= '0;
            FRAME_VALID <= 1'b0;
            ONES        <= '0;
            MATCH       <= 1'b0;
            LOCKED      <= 1'b0;
            ERR_CNT     <= '0;
        end else begin
            FRAME_VALID <= 1'b0;
            unique case (state)
                HUNT: begin
                    if (SYNC) begin
                        shreg[0] <= SIN;
                        slot     <= CW'(1);
                        state    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (slot == '0) begin
                        if (SYNC) begin
                            shreg[0] <= SIN;
                            slot     <= CW'(1);
                        end else begin
                            ERR_CNT <= err_nx;
                            LOCKED  <= 1'b0;
                            good    <= '0;
                            state   <= HUNT;
                        end
                    end else if (SYNC) begin
                        ERR_CNT  <= err_nx;
                        LOCKED   <= 1'b0;
                        good     <= '0;
                        shreg[0] <= SIN;
                        slot     <= CW'(1);
                    end else if (slot == LAST) begin
                        FRAME       <= word;
                        ONES        <= ones_nx;
                        MATCH       <= word_ok;
                        FRAME_VALID <= 1'b1;
                        slot        <= '0;
                        if (word_ok) begin
                            if (good != GOOD_MAX) begin
                                good <= good + GW'(1);
                            end
                            LOCKED <= (good >= GOOD_PRE);
                        end else begin
                            ERR_CNT <= err_nx;
                            good    <= '0;
                            LOCKED  <= 1'b0;
                        end
                    end else begin
                        shreg[slot] <= SIN;
                        slot        <= slot + CW'(1);
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_checker.sv
// tb_serial_frame_checker: randomized frame-level stimulus, transaction model
// and a scoreboard monitor that checks every FRAME_VALID.
module tb_serial_frame_checker;

    localparam logic [9:0] EXP    = 10'h03F;
    localparam int         LOCK_N = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SIN = 1'b0;
    logic       SYNC = 1'b0;
    logic [9:0] FRAME;
    logic       FRAME_VALID;
    logic [3:0] ONES;
    logic       MATCH;
    logic       LOCKED;
    logic [7:0] ERR_CNT;

    serial_frame_checker dut (
        .CLK(CLK), .RST(RST), .SIN(SIN), .SYNC(SYNC),
        .FRAME(FRAME), .FRAME_VALID(FRAME_VALID), .ONES(ONES),
        .MATCH(MATCH), .LOCKED(LOCKED), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [9:0]  frame;
        logic [3:0]  ones;
        logic        match;
        logic        locked;
        logic [7:0]  err;
        int unsigned at;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    int m_err = 0;
    int m_good = 0;
    bit m_chain = 0;
    bit m_partial = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic int popc(logic [9:0] w);
        int n = 0;
        for (int i = 0; i < 10; i++) n += int'(w[i]);
        return n;
    endfunction

    function automatic void bump_err();
        if (m_err < 255) m_err++;
    endfunction

    function automatic void model_reset();
        m_err = 0;
        m_good = 0;
        m_chain = 0;
        m_partial = 0;
    endfunction

    task automatic drive(bit s, bit sy, bit r = 1'b0);
        @(negedge CLK);
        SIN = s;
        SYNC = sy;
        RST = r;
    endtask

    task automatic start_frame();
        if (m_partial) begin
            bump_err();
            m_good = 0;
        end
        m_partial = 0;
    endtask

    task automatic op_full(logic [9:0] w);
        exp_t e;
        start_frame();
        for (int i = 0; i < 10; i++) drive(w[i], i == 0);
        if (w == EXP) begin
            if (m_good < LOCK_N) m_good++;
        end else begin
            bump_err();
            m_good = 0;
        end
        e.frame  = w;
        e.ones   = 4'(popc(w));
        e.match  = (w == EXP);
        e.locked = (m_good >= LOCK_N);
        e.err    = 8'(m_err);
        e.at     = cyc + 1;
        q.push_back(e);
        m_chain = 1;
    endtask

    task automatic op_partial(int k);
        start_frame();
        for (int i = 0; i < k; i++) drive(1'($urandom), i == 0);
        m_partial = 1;
        m_chain = 0;
    endtask

    task automatic op_gap(int n);
        for (int i = 0; i < n; i++) drive(1'($urandom), 1'b0);
        if (m_chain) begin
            bump_err();
            m_good = 0;
        end
        m_chain = 0;
    endtask

    task automatic check_idle(string tag);
        @(posedge CLK);
        #1;
        check({tag, "_frame"}, FRAME, 0);
        check({tag, "_valid"}, FRAME_VALID, 0);
        check({tag, "_ones"}, ONES, 0);
        check({tag, "_match"}, MATCH, 0);
        check({tag, "_locked"}, LOCKED, 0);
        check({tag, "_err"}, ERR_CNT, 0);
    endtask

    exp_t me;
    always begin
        @(posedge CLK);
        #1;
        if (q.size() > 0 && cyc > q[0].at) begin
            checks++;
            $display("FAIL missed_valid: none at cycle %0d expected one", q[0].at);
            void'(q.pop_front());
        end
        if (FRAME_VALID === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_valid: got valid at %0d expected none", cyc);
            end else begin
                me = q.pop_front();
                check("latency", cyc, me.at);
                check("frame", FRAME, me.frame);
                check("ones", ONES, me.ones);
                check("match", MATCH, me.match);
                check("locked", LOCKED, me.locked);
                check("err_cnt", ERR_CNT, me.err);
            end
        end
    end

    initial begin
        int kind;
        int prev;
        repeat (2) drive(1'($urandom), 1'($urandom), 1'b1);
        check_idle("reset");
        for (int i = 0; i < 20; i++) drive(1'($urandom), 1'b0);
        check_idle("hunt");
        model_reset();

        repeat (4) op_full(EXP);
        op_full(10'h0BF);
        repeat (3) op_full(EXP);
        op_partial(4);
        op_full(EXP);
        op_full(EXP);
        op_gap(7);
        op_full(EXP);

        prev = 0;
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            if (kind >= 8 && prev == 1) kind = 0;
            if (kind < 6) begin
                op_full($urandom_range(0, 1) ? EXP : 10'($urandom));
                prev = 0;
            end else if (kind < 8) begin
                op_partial($urandom_range(1, 9));
                prev = 1;
            end else begin
                op_gap($urandom_range(1, 12));
                prev = 2;
            end
        end
        op_full(EXP);

        repeat (300) op_partial($urandom_range(1, 9));
        op_full(EXP);
        repeat (3) drive(1'($urandom), 1'b1);
        model_reset();

        for (int i = 0; i < 5; i++) drive(1'($urandom), i == 0);
        drive(1'($urandom), 1'($urandom), 1'b1);
        model_reset();
        for (int i = 0; i < 15; i++) drive(1'($urandom), 1'b0);
        check_idle("midreset");
        check("queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
